// File: rtl/sargantana_icache_pkg.sv
// Shared types and constants for the L1 instruction-cache refill path.
package sargantana_icache_pkg;

  localparam int PADDR_SIZE  = 40;
  localparam int SET_WIDHT   = 256;
  localparam int WORD_SIZE   = 64;
  localparam int INV_PADDR_W = 12;
  localparam int LINE_OFF_W  = $clog2(SET_WIDHT / 8);

  localparam int IFILL_N_BEATS = SET_WIDHT / WORD_SIZE;
  localparam int IFILL_CNT_W   = $clog2(IFILL_N_BEATS);

  typedef struct packed {
    logic                  valid;
    logic [1:0]            way;
    logic [PADDR_SIZE-1:0] paddr;
  } ifill_req_o_t;

  typedef struct packed {
    logic                   valid;
    logic [INV_PADDR_W-1:0] paddr;
  } inv_t;

  typedef struct packed {
    logic                   valid;
    logic                   ack;
    logic [SET_WIDHT-1:0]   data;
    logic [IFILL_CNT_W-1:0] beat;
    inv_t                   inv;
  } ifill_resp_i_t;

  typedef enum logic [2:0] {
    IFILL_IDLE  = 3'd0,
    IFILL_REQ   = 3'd1,
    IFILL_BEATS = 3'd2,
    IFILL_RESP  = 3'd3,
    IFILL_DRAIN = 3'd4
  } ifill_state_t;

  function automatic logic [PADDR_SIZE-1:0] line_align(input logic [PADDR_SIZE-1:0] a);
    return a & ~{{(PADDR_SIZE-LINE_OFF_W){1'b0}}, {LINE_OFF_W{1'b1}}};
  endfunction

endpackage

// File: rtl/sargantana_icache_ifill_if.sv
// Memory-side read port of the refill engine: one request channel, one beat channel.
interface sargantana_icache_ifill_if;
  import sargantana_icache_pkg::*;

  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i;
  logic [PADDR_SIZE-1:0] mem_req_addr_o;
  logic                  mem_resp_valid_i;
  logic [WORD_SIZE-1:0]  mem_resp_data_i;

  modport master (
    output mem_req_valid_o, mem_req_addr_o,
    input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i
  );

  modport slave (
    input  mem_req_valid_o, mem_req_addr_o,
    output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i
  );

endinterface

// File: rtl/sargantana_icache_ifill_chk.sv
// Simulation-time protocol checks for the refill engine.
module sargantana_icache_ifill_chk
  import sargantana_icache_pkg::*;
#(
  parameter int PADDR_W = PADDR_SIZE
) (
  input logic               clk_i,
  input logic               rstn_i,
  input ifill_state_t       i_state,
  input logic [1:0]         i_way,
  input logic               i_req_valid,
  input logic               i_req_ready,
  input logic [PADDR_W-1:0] i_req_addr,
  input logic               i_resp_valid
);

  a_beat_in_window: assert property (@(posedge clk_i) disable iff (!rstn_i)
    i_resp_valid |-> (i_state == IFILL_BEATS || i_state == IFILL_DRAIN));

  a_addr_stable: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (i_req_valid && !i_req_ready) |=> $stable(i_req_addr));

  a_way_stable: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (i_state != IFILL_IDLE) |=> $stable(i_way));

endmodule

// File: rtl/sargantana_icache_ifill_linebuf.sv
// Beat counter and line assembly register; beat cnt lands in slot cnt.
module sargantana_icache_ifill_linebuf #(
  parameter int N_BEATS    = 4,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          i_clr,
  input  logic                          i_cnt_clr,
  input  logic                          i_we,
  input  logic                          i_inc,
  input  logic [BEAT_WIDTH-1:0]         i_data,
  output logic [$clog2(N_BEATS)-1:0]    o_cnt,
  output logic [N_BEATS*BEAT_WIDTH-1:0] o_line
);

  logic [$clog2(N_BEATS)-1:0]    r_cnt;
  logic [N_BEATS*BEAT_WIDTH-1:0] r_line;

  // Line storage: cleared when a new miss is accepted, written one beat at a time.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_line <= {(N_BEATS*BEAT_WIDTH){1'b0}};
    end else if (i_clr) begin
      r_line <= {(N_BEATS*BEAT_WIDTH){1'b0}};
    end else if (i_we) begin
      r_line[int'(r_cnt)*BEAT_WIDTH +: BEAT_WIDTH] <= i_data;
    end
  end

  // Beat counter; natural wrap takes it back to zero after the last beat.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= {$clog2(N_BEATS){1'b0}};
    end else if (i_clr || i_cnt_clr) begin
      r_cnt <= {$clog2(N_BEATS){1'b0}};
    end else if (i_inc) begin
      r_cnt <= r_cnt + {{($clog2(N_BEATS)-1){1'b0}}, 1'b1};
    end
  end

  assign o_cnt  = r_cnt;
  assign o_line = r_line;

endmodule

// File: rtl/sargantana_icache_ifill.sv
// Icache line refill engine: one miss -> one line-aligned read -> N_BEATS beats -> one line.
module sargantana_icache_ifill
  import sargantana_icache_pkg::*;
#(
  parameter int N_BEATS    = IFILL_N_BEATS,
  parameter int BEAT_WIDTH = WORD_SIZE,
  parameter int PADDR_SIZE = sargantana_icache_pkg::PADDR_SIZE
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  ifill_req_o_t                   ifill_req_i,
  output ifill_resp_i_t                  ifill_resp_o,
  input  logic                           flush_i,
  input  logic                           inval_valid_i,
  input  logic [INV_PADDR_W-1:0]         inval_paddr_i,
  sargantana_icache_ifill_if.master      mem
);

  localparam int CNT_W = $clog2(N_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  ifill_state_t                  r_state, w_next;
  logic [PADDR_SIZE-1:0]         r_addr;
  logic [1:0]                    r_way;
  logic                          r_ack, r_req_valid, r_resp_valid, r_inv_valid;
  logic [CNT_W-1:0]              r_beat, w_cnt;
  logic [INV_PADDR_W-1:0]        r_inv_paddr;
  logic [N_BEATS*BEAT_WIDTH-1:0] w_line;
  logic                          w_accept, w_last, w_we, w_inc, w_cnt_clr;

  // Next-state and datapath strobes.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_we      = 1'b0;
    w_inc     = 1'b0;
    w_cnt_clr = 1'b0;
    w_last    = (w_cnt == LAST_BEAT);
    case (r_state)
      IFILL_IDLE: begin
        if (ifill_req_i.valid && !flush_i) begin
          w_accept = 1'b1;
          w_next   = IFILL_REQ;
        end else begin
          w_next = IFILL_IDLE;
        end
      end
      IFILL_REQ: begin
        // A handshake already taken by memory must be drained even if flushed.
        if (mem.mem_req_ready_i) begin
          w_cnt_clr = 1'b1;
          w_next    = flush_i ? IFILL_DRAIN : IFILL_BEATS;
        end else if (flush_i) begin
          w_next = IFILL_IDLE;
        end else begin
          w_next = IFILL_REQ;
        end
      end
      IFILL_BEATS: begin
        if (mem.mem_resp_valid_i) begin
          w_we  = 1'b1;
          w_inc = 1'b1;
          if (w_last) begin
            w_next = flush_i ? IFILL_IDLE : IFILL_RESP;
          end else begin
            w_next = flush_i ? IFILL_DRAIN : IFILL_BEATS;
          end
        end else if (flush_i) begin
          w_next = IFILL_DRAIN;
        end else begin
          w_next = IFILL_BEATS;
        end
      end
      IFILL_RESP: begin
        w_next = IFILL_IDLE;
      end
      IFILL_DRAIN: begin
        if (mem.mem_resp_valid_i) begin
          w_inc  = 1'b1;
          w_next = w_last ? IFILL_IDLE : IFILL_DRAIN;
        end else begin
          w_next = IFILL_DRAIN;
        end
      end
      default: begin
        w_next = IFILL_IDLE;
      end
    endcase
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= IFILL_IDLE;
      r_addr       <= {PADDR_SIZE{1'b0}};
      r_way        <= 2'b00;
      r_ack        <= 1'b0;
      r_req_valid  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_beat       <= {CNT_W{1'b0}};
    end else begin
      r_state      <= w_next;
      r_ack        <= w_accept;
      r_req_valid  <= (w_next == IFILL_REQ);
      r_resp_valid <= (w_next == IFILL_RESP);
      r_beat       <= (w_next == IFILL_RESP) ? LAST_BEAT : {CNT_W{1'b0}};
      if (w_accept) begin
        r_addr <= line_align(ifill_req_i.paddr);
        r_way  <= ifill_req_i.way;
      end
    end
  end

  // Invalidation side path, independent of the refill FSM.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_inv_valid <= 1'b0;
      r_inv_paddr <= {INV_PADDR_W{1'b0}};
    end else begin
      r_inv_valid <= inval_valid_i;
      r_inv_paddr <= inval_paddr_i;
    end
  end

  sargantana_icache_ifill_linebuf #(
    .N_BEATS    (N_BEATS),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_linebuf (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .i_clr     (w_accept),
    .i_cnt_clr (w_cnt_clr),
    .i_we      (w_we),
    .i_inc     (w_inc),
    .i_data    (mem.mem_resp_data_i),
    .o_cnt     (w_cnt),
    .o_line    (w_line)
  );

  sargantana_icache_ifill_chk #(
    .PADDR_W (PADDR_SIZE)
  ) u_chk (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .i_state      (r_state),
    .i_way        (r_way),
    .i_req_valid  (r_req_valid),
    .i_req_ready  (mem.mem_req_ready_i),
    .i_req_addr   (r_addr),
    .i_resp_valid (mem.mem_resp_valid_i)
  );

  assign mem.mem_req_valid_o = r_req_valid;
  assign mem.mem_req_addr_o  = r_addr;
  assign ifill_resp_o = {r_resp_valid, r_ack, w_line, r_beat, r_inv_valid, r_inv_paddr};

endmodule

// File: tb/tb_sargantana_icache_ifill.sv
// Directed bench: table of refill scenarios plus hand sequences for flush and reset.
module tb_sargantana_icache_ifill;
  import sargantana_icache_pkg::*;

  typedef struct {
    logic [39:0] paddr;
    logic [1:0]  way;
    int          rdy;
    int          gap  [4];
    logic [63:0] beat [4];
    logic        hold;
    logic        inv;
    logic [39:0] exp_addr;
  } vec_t;

  logic          clk, rstn, flush, inval_valid;
  logic [11:0]   inval_paddr;
  ifill_req_o_t  req;
  ifill_resp_i_t resp;
  vec_t          vecs [4];
  int            n_pass, n_tot, n_ack, n_resp, n_hs;
  int            a0, r0, h0;

  sargantana_icache_ifill_if mem_if ();

  sargantana_icache_ifill dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .ifill_req_i   (req),
    .ifill_resp_o  (resp),
    .flush_i       (flush),
    .inval_valid_i (inval_valid),
    .inval_paddr_i (inval_paddr),
    .mem           (mem_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled on the active edge.
  always @(posedge clk) begin
    if (resp.ack) n_ack++;
    if (resp.valid) n_resp++;
    if (mem_if.mem_req_valid_o && mem_if.mem_req_ready_i) n_hs++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b want %0b", nm, act, exp);
  endtask

  task automatic chkw(input string nm, input logic [272:0] act, input logic [272:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic do_refill(input vec_t v);
    int ack0, resp0, hs0;
    logic [255:0] line;
    ack0 = n_ack; resp0 = n_resp; hs0 = n_hs;
    line = {v.beat[3], v.beat[2], v.beat[1], v.beat[0]};
    req.valid = 1'b1; req.way = v.way; req.paddr = v.paddr;
    step();
    chk1("ack", resp.ack, 1'b1);
    chk1("mreq_valid", mem_if.mem_req_valid_o, 1'b1);
    chkw("mreq_addr", 273'(mem_if.mem_req_addr_o), 273'(v.exp_addr));
    if (!v.hold) req.valid = 1'b0;
    mem_if.mem_req_ready_i = (v.rdy == 0);
    for (int k = 0; k < v.rdy; k++) begin
      step();
      chk1("ack_once", resp.ack, 1'b0);
      chkw("mreq_wait", 273'({mem_if.mem_req_valid_o, mem_if.mem_req_addr_o}), 273'({1'b1, v.exp_addr}));
      if (k == v.rdy - 1) mem_if.mem_req_ready_i = 1'b1;
    end
    step();
    mem_if.mem_req_ready_i = 1'b0;
    chk1("mreq_drop", mem_if.mem_req_valid_o, 1'b0);
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < v.gap[b]; g++) step();
      mem_if.mem_resp_valid_i = 1'b1;
      mem_if.mem_resp_data_i  = v.beat[b];
      if (b == 3) begin
        chk1("resp_early", resp.valid, 1'b0);
        if (v.inv) begin
          inval_valid = 1'b1; inval_paddr = 12'hA40;
        end
      end
      step();
      mem_if.mem_resp_valid_i = 1'b0;
      inval_valid = 1'b0;
    end
    chk1("resp_valid", resp.valid, 1'b1);
    chkw("resp_data", 273'(resp.data), 273'(line));
    chkw("resp_beat", 273'(resp.beat), 273'(2'd3));
    if (v.inv) begin
      chk1("inv_valid", resp.inv.valid, 1'b1);
      chkw("inv_paddr", 273'(resp.inv.paddr), 273'(12'hA40));
    end
    step();
    chk1("resp_pulse", resp.valid, 1'b0);
    chk1("inv_pulse", resp.inv.valid, 1'b0);
    chk1("ack_idle", resp.ack, 1'b0);
    chki("n_ack", n_ack - ack0, 1);
    chki("n_resp", n_resp - resp0, 1);
    chki("n_hs", n_hs - hs0, 1);
  endtask

  initial begin
    n_pass = 0; n_tot = 0; n_ack = 0; n_resp = 0; n_hs = 0;
    vecs[0] = '{40'h00_8000_1234, 2'd2, 0, '{0, 0, 0, 0},
                '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                  64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444},
                1'b0, 1'b0, 40'h00_8000_1220};
    vecs[1] = '{40'h12_3456_789F, 2'd1, 5, '{1, 3, 2, 1},
                '{64'hA5A5_0000_0000_0001, 64'hA5A5_0000_0000_0002,
                  64'hA5A5_0000_0000_0003, 64'hA5A5_0000_0000_0004},
                1'b0, 1'b1, 40'h12_3456_7880};
    vecs[2] = '{40'hFF_FFFF_FFFF, 2'd3, 1, '{0, 2, 0, 1},
                '{64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF,
                  64'hCAFE_F00D_CAFE_F00D, 64'h8000_0000_0000_0001},
                1'b1, 1'b0, 40'hFF_FFFF_FFE0};
    vecs[3] = '{40'h00_0000_0020, 2'd0, 2, '{0, 0, 0, 0},
                '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                  64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF},
                1'b0, 1'b0, 40'h00_0000_0020};

    rstn = 1'b0; flush = 1'b0; inval_valid = 1'b0; inval_paddr = 12'h000;
    req = '0;
    mem_if.mem_req_ready_i = 1'b0; mem_if.mem_resp_valid_i = 1'b0;
    mem_if.mem_resp_data_i = 64'h0;
    step(); step();
    chkw("reset_resp", resp, 273'b0);
    chk1("reset_mreq_valid", mem_if.mem_req_valid_o, 1'b0);
    chkw("reset_mreq_addr", 273'(mem_if.mem_req_addr_o), 273'b0);
    rstn = 1'b1;
    step();

    // Flush in IDLE blocks acceptance.
    req.valid = 1'b1; req.paddr = 40'h00_0000_1000; flush = 1'b1;
    step();
    chk1("idle_flush_ack", resp.ack, 1'b0);
    chk1("idle_flush_mreq", mem_if.mem_req_valid_o, 1'b0);
    req.valid = 1'b0; flush = 1'b0;
    step();

    // Flush while waiting for the memory handshake.
    h0 = n_hs; r0 = n_resp;
    req.valid = 1'b1; req.way = 2'd1; req.paddr = 40'h00_4000_0044;
    step();
    chk1("reqflush_ack", resp.ack, 1'b1);
    req.valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk1("reqflush_mreq", mem_if.mem_req_valid_o, 1'b0);
    step(); step();
    chki("reqflush_hs", n_hs - h0, 0);
    chki("reqflush_resp", n_resp - r0, 0);

    // Flush after beat 1, remaining beats drained (second flush during drain ignored).
    h0 = n_hs; r0 = n_resp;
    req.valid = 1'b1; req.paddr = 40'h00_5000_0100;
    step();
    req.valid = 1'b0; mem_if.mem_req_ready_i = 1'b1;
    step();
    mem_if.mem_req_ready_i = 1'b0;
    mem_if.mem_resp_valid_i = 1'b1; mem_if.mem_resp_data_i = 64'hBAD0_0000_0000_0000;
    step();
    mem_if.mem_resp_data_i = 64'hBAD1_0000_0000_0001;
    step();
    mem_if.mem_resp_valid_i = 1'b0; flush = 1'b1;
    step();
    mem_if.mem_resp_valid_i = 1'b1; mem_if.mem_resp_data_i = 64'hBAD2_0000_0000_0002;
    step();
    flush = 1'b0; mem_if.mem_resp_data_i = 64'hBAD3_0000_0000_0003;
    step();
    mem_if.mem_resp_valid_i = 1'b0;
    chk1("drain_no_resp0", resp.valid, 1'b0);
    step();
    chk1("drain_no_resp1", resp.valid, 1'b0);
    chki("drain_hs", n_hs - h0, 1);
    chki("drain_resp", n_resp - r0, 0);

    for (int i = 0; i < 4; i++) do_refill(vecs[i]);

    // Asynchronous reset in BEATS after two beats.
    req.valid = 1'b1; req.way = 2'd3; req.paddr = 40'h00_6000_0000;
    step();
    req.valid = 1'b0; mem_if.mem_req_ready_i = 1'b1;
    step();
    mem_if.mem_req_ready_i = 1'b0;
    mem_if.mem_resp_valid_i = 1'b1; mem_if.mem_resp_data_i = 64'hAAAA_AAAA_AAAA_AAAA;
    step();
    mem_if.mem_resp_data_i = 64'hBBBB_BBBB_BBBB_BBBB;
    step();
    mem_if.mem_resp_valid_i = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chkw("arst_resp", resp, 273'b0);
    chk1("arst_mreq_valid", mem_if.mem_req_valid_o, 1'b0);
    chkw("arst_mreq_addr", 273'(mem_if.mem_req_addr_o), 273'b0);
    step();
    rstn = 1'b1;
    step();
    do_refill(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/sargantana_icache_ifill.md
Name: sargantana_icache_ifill

Overview:
- Refill engine directly downstream of the L1 instruction cache.
- Accepts one line-miss request (valid/way/paddr, ifill_req_o_t), issues a line-aligned read to the L2/memory port, and collects N_BEATS 64-bit beats into a 256-bit line.
- Returns the line to the icache as ifill_resp_i_t.
- Also registers external invalidations onto the response inv field, and supports a flush that aborts an in-flight refill.

Parameters:
- N_BEATS, 4, beats per cache line.
- BEAT_WIDTH, 64, bits per memory beat; N_BEATS*BEAT_WIDTH equals the 256-bit line.
- PADDR_SIZE, sargantana_icache_pkg::PADDR_SIZE (40), physical address width.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; one clock, asynchronous active-low reset.
- ifill_req_i  in  ifill_req_o_t (1+2+PADDR_SIZE)  miss request from the icache.
- ifill_resp_o  out  ifill_resp_i_t (273)  valid, ack, data[255:0], beat[1:0], inv{valid,paddr[11:0]}.
- flush_i  in  1  abort the current refill; no response is produced for it.
- inval_valid_i  in  1  external invalidation strobe.
- inval_paddr_i  in  12  index bits of the line to invalidate.
- mem_req_valid_o  out  1  memory read request.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_req_addr_o  out  PADDR_SIZE  line address; bits [4:0] are always zero.
- mem_resp_valid_i  in  1  beat valid.
- mem_resp_data_i  in  BEAT_WIDTH  beat payload; beats arrive in ascending address order.

Behaviour:
- Reset (rstn_i low, asynchronous):
  - state IDLE, beat counter 0, line buffer 0.
  - All ifill_resp_o fields 0; mem_req_valid_o 0; mem_req_addr_o 0.
- All ifill_resp_o fields and mem_req_* outputs are registered.
- Per-state behaviour:
  - IDLE: if ifill_req_i.valid and !flush_i, latch paddr with bits [4:0] cleared, latch way, go to REQ. ack=1 for exactly the next cycle.
  - REQ: mem_req_valid_o=1 and mem_req_addr_o=latched address, held stable until mem_req_ready_i. On handshake, clear counter and go to BEATS. If flush_i before the handshake, go to IDLE with no memory request issued.
  - BEATS: each mem_resp_valid_i writes data into line slot [BEAT_WIDTH*cnt +: BEAT_WIDTH], then cnt++. When the beat with cnt==N_BEATS-1 is captured, go to RESP. flush_i goes to DRAIN, keeping the counter.
  - RESP: valid=1, data=assembled line, beat=N_BEATS-1 for one cycle, then IDLE.
  - DRAIN: consumes the remaining beats with no response. After beat N_BEATS-1 go to IDLE. A flush_i arriving during DRAIN has no further effect.
- Request acceptance:
  - Requests are accepted only in IDLE.
  - The requester holds valid until it sees ack; a held valid in any other state is neither acked nor queued.
  - The ack cycle is spent in REQ, so a still-held valid is never double-accepted.
- Latency:
  - Acceptance edge t gives ack and mem_req_valid_o high in cycle t+1.
  - With ready=1 and back-to-back beats in cycles t+2..t+5, resp.valid is high in cycle t+6.
  - Minimum miss-to-line is 6 cycles.
- flush_i in the same cycle as RESP: the response is still delivered, because the line is complete.
- flush_i in IDLE: blocks acceptance that cycle.
- mem_resp_valid_i outside BEATS/DRAIN is ignored and asserts in simulation.
- Counter width: $clog2(N_BEATS); it wraps to 0 on leaving BEATS/DRAIN.
- Invalidation path, independent of the FSM:
  - inv.valid and inv.paddr are registered copies of inval_valid_i/inval_paddr_i with 1-cycle latency, high for one cycle per strobe.
  - It may coincide with resp.valid; the icache applies inv first.
- Reset mid-refill returns to IDLE immediately. The memory side is assumed to be reset together with this block.

Decomposition:
- sargantana_icache_pkg holds:
  - ifill_req_o_t, ifill_resp_i_t, inv_t.
  - A new enum ifill_state_t {IFILL_IDLE, IFILL_REQ, IFILL_BEATS, IFILL_RESP, IFILL_DRAIN}.
  - IFILL_N_BEATS = SET_WIDHT/WORD_SIZE.
- One natural sub-module: sargantana_icache_ifill_linebuf, holding the beat counter and the N_BEATS x BEAT_WIDTH assembly register with write-enable/clear.

Test Plan:
- Basic refill: request paddr=0x80001234, way=2; ready=1; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 in consecutive cycles.
  - Expect mem_req_addr_o=0x80001220 and ack exactly one cycle.
  - Expect resp.valid at acceptance+6 with data[63:0]=0x11..11 and data[255:192]=0x44..44.
- Backpressure and gaps: ready held low 5 cycles; beats with 1-3 idle gaps.
  - Expect address stable while waiting, a single handshake, and one resp.valid pulse with correct data ordering.
- Held request: keep ifill_req_i.valid high through the whole refill.
  - Expect exactly one ack and one mem request per refill; the second ack only after returning to IDLE.
- Flush cases:
  - flush_i while in REQ (ready=0): no mem request handshake, no response, returns to IDLE.
  - flush_i after beat 1: beats 2-3 drained, no resp.valid.
  - Next request: data contains only its own beats.
- Invalidation concurrent with RESP: inval_valid_i with inval_paddr_i=0xA40 one cycle before resp.valid.
  - Expect inv.valid=1, inv.paddr=0xA40 and resp.valid=1 in the same cycle.
- Asynchronous reset in BEATS after 2 beats:
  - Expect all outputs 0 immediately.
  - After release, a fresh request completes normally with counter starting at 0.
